// File: rtl/tone_period_detector.sv
// Recovers the switch period of a square wave by timing rising edges, with lock
// qualification over consecutive matching periods and a silence timeout.
module tone_period_detector #(
    parameter int PERIOD_WIDTH   = 24,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 16777215,
    parameter int TOLERANCE      = 2,
    parameter int STABLE_COUNT   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wave_in,
    output logic [PERIOD_WIDTH-1:0] tone_period,
    output logic                    tone_valid,
    output logic                    locked,
    output logic                    silent
);

    localparam int CW = PERIOD_WIDTH + 1;
    localparam int MW = $clog2(STABLE_COUNT + 1);
    localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TOL_VAL     = CW'(TOLERANCE);
    localparam logic [MW-1:0] STABLE_VAL  = MW'(STABLE_COUNT);

    typedef enum logic [1:0] {
        S_SILENT,
        S_ACQUIRE,
        S_LOCKED
    } state_t;

    state_t                  r_state;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic                    r_syncPrev;
    logic [CW-1:0]           r_cnt;
    logic [CW-1:0]           r_cand;
    logic [MW-1:0]           r_matchCnt;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic                    r_valid;
    logic                    r_locked;
    logic                    r_silent;

    logic                    w_rise;
    logic                    w_timeout;
    logic                    w_match;
    logic [CW-1:0]           w_meas;
    logic [CW-1:0]           w_diff;
    logic [MW-1:0]           w_matchNext;
    logic [PERIOD_WIDTH-1:0] w_half;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync     <= '0;
            r_syncPrev <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], wave_in};
            r_syncPrev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_rise      = r_sync[SYNC_STAGES-1] & ~r_syncPrev;
    assign w_meas      = r_cnt + CW'(1);
    assign w_diff      = (w_meas >= r_cand) ? (w_meas - r_cand) : (r_cand - w_meas);
    assign w_match     = (w_diff <= TOL_VAL);
    assign w_matchNext = ((r_matchCnt != '0) && w_match) ? (r_matchCnt + MW'(1)) : MW'(1);
    assign w_half      = w_meas[CW-1:1];
    // Fires on the cycle the counter steps onto TIMEOUT_CYCLES; a rise takes priority.
    assign w_timeout   = (r_cnt == TIMEOUT_VAL - CW'(1)) && !w_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_rise) begin
            r_cnt <= '0;
        end else if (r_cnt != TIMEOUT_VAL) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_SILENT;
            r_cand     <= '0;
            r_matchCnt <= '0;
            r_period   <= '0;
            r_valid    <= 1'b0;
            r_locked   <= 1'b0;
            r_silent   <= 1'b1;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_SILENT: begin
                    if (w_rise) begin
                        r_state    <= S_ACQUIRE;
                        r_matchCnt <= '0;
                    end
                end
                S_ACQUIRE: begin
                    if (w_rise) begin
                        r_cand     <= w_meas;
                        r_matchCnt <= w_matchNext;
                        if (w_matchNext == STABLE_VAL) begin
                            r_state  <= S_LOCKED;
                            r_locked <= 1'b1;
                            r_silent <= 1'b0;
                            r_period <= w_half;
                            r_valid  <= (w_half != r_period);
                        end
                    end else if (w_timeout) begin
                        r_state  <= S_SILENT;
                        r_locked <= 1'b0;
                        r_silent <= 1'b1;
                        r_period <= '0;
                        r_valid  <= (r_period != '0);
                    end
                end
                S_LOCKED: begin
                    if (w_rise) begin
                        r_cand <= w_meas;
                        // The old period stays published until a fresh lock replaces it.
                        if (!w_match) begin
                            r_state    <= S_ACQUIRE;
                            r_locked   <= 1'b0;
                            r_matchCnt <= MW'(1);
                        end
                    end else if (w_timeout) begin
                        r_state  <= S_SILENT;
                        r_locked <= 1'b0;
                        r_silent <= 1'b1;
                        r_period <= '0;
                        r_valid  <= (r_period != '0);
                    end
                end
                default: begin
                    r_state <= S_SILENT;
                end
            endcase
        end
    end

    assign tone_period = r_period;
    assign tone_valid  = r_valid;
    assign locked      = r_locked;
    assign silent      = r_silent;

endmodule

// File: tb/tb_tone_period_detector.sv
// Directed bench for tone_period_detector: lock, retune, jitter tolerance,
// silence timeout and reset while locked, all driven and sampled on the falling edge.
module tb_tone_period_detector;

    localparam int PW      = 24;
    localparam int TIMEOUT = 10000;

    logic          clk;
    logic          rst;
    logic          wave_in;
    logic [PW-1:0] tone_period;
    logic          tone_valid;
    logic          locked;
    logic          silent;

    int            totalChecks;
    int            badChecks;
    int            validCount;
    logic [PW-1:0] lastValidPeriod;

    tone_period_detector #(
        .PERIOD_WIDTH  (PW),
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(TIMEOUT),
        .TOLERANCE     (2),
        .STABLE_COUNT  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wave_in    (wave_in),
        .tone_period(tone_period),
        .tone_valid (tone_valid),
        .locked     (locked),
        .silent     (silent)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    // Pulse monitor, sampled just after each rising edge.
    initial begin
        validCount      = 0;
        lastValidPeriod = '0;
        forever begin
            @(posedge clk);
            #1;
            if (tone_valid) begin
                validCount      = validCount + 1;
                lastValidPeriod = tone_period;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks = totalChecks + 1;
        if (observed !== expected) begin
            badChecks = badChecks + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One full wave period: high for hHigh clocks, then low for hLow clocks.
    task automatic applyStimulus(input int hHigh, input int hLow);
        wave_in = 1'b1;
        repeat (hHigh) @(negedge clk);
        wave_in = 1'b0;
        repeat (hLow) @(negedge clk);
    endtask

    task automatic checkState(input string tag, input int expLocked, input int expSilent,
                              input int expPeriod, input int expValids);
        checkOutput({tag, ".locked"}, 32'(locked), 32'(expLocked));
        checkOutput({tag, ".silent"}, 32'(silent), 32'(expSilent));
        checkOutput({tag, ".period"}, 32'(tone_period), 32'(expPeriod));
        checkOutput({tag, ".valids"}, 32'(validCount), 32'(expValids));
    endtask

    initial begin
        totalChecks = 0;
        badChecks   = 0;
        rst         = 1'b1;
        wave_in     = 1'b0;
        repeat (2) @(negedge clk);
        checkState("reset", 0, 1, 0, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checkState("idle", 0, 1, 0, 0);

        // Lock on 2000-clock periods at the third rise.
        applyStimulus(1000, 1000);
        checkState("lock1", 0, 1, 0, 0);
        applyStimulus(1000, 1000);
        checkState("lock2", 0, 1, 0, 0);
        applyStimulus(1000, 1000);
        checkState("lock3", 1, 0, 1000, 1);
        checkOutput("lock3.pulseVal", 32'(lastValidPeriod), 32'd1000);

        // Retune to 1000-clock periods.
        applyStimulus(500, 500);
        checkState("retune4", 1, 0, 1000, 1);
        applyStimulus(500, 500);
        checkState("retune5", 0, 0, 1000, 1);
        applyStimulus(500, 500);
        checkState("retune6", 1, 0, 500, 2);
        checkOutput("retune6.pulseVal", 32'(lastValidPeriod), 32'd500);

        // Jitter of 2000/2002 stays inside tolerance.
        applyStimulus(1000, 1000);
        checkState("jit7", 1, 0, 500, 2);
        applyStimulus(1001, 1001);
        checkState("jit8", 0, 0, 500, 2);
        applyStimulus(1000, 1000);
        checkState("jit9", 1, 0, 1001, 3);
        applyStimulus(1001, 1001);
        checkState("jit10", 1, 0, 1001, 3);
        applyStimulus(1000, 1000);
        checkState("jit11", 1, 0, 1001, 3);

        // A difference of 3 is one past tolerance and must break lock.
        applyStimulus(1000, 1003);
        checkState("tol12", 1, 0, 1001, 3);
        applyStimulus(1000, 1000);
        checkState("tol13", 0, 0, 1001, 3);
        applyStimulus(1000, 1000);
        checkState("tol14", 0, 0, 1001, 3);

        // Relock at 1000, then hold low and time the silence boundary.
        wave_in = 1'b1;
        repeat (3) @(negedge clk);
        checkState("relock15", 1, 0, 1000, 4);
        repeat (997) @(negedge clk);
        wave_in = 1'b0;
        repeat (TIMEOUT + 2 - 1000) @(negedge clk);
        checkState("preSilence", 1, 0, 1000, 4);
        @(negedge clk);
        checkState("silence", 0, 1, 0, 5);
        checkOutput("silence.pulseVal", 32'(lastValidPeriod), 32'd0);
        repeat (50) @(negedge clk);
        checkState("silenceHold", 0, 1, 0, 5);

        // Lock again, then reset while locked.
        applyStimulus(1000, 1000);
        applyStimulus(1000, 1000);
        applyStimulus(1000, 1000);
        checkState("lock18", 1, 0, 1000, 6);
        wave_in = 1'b1;
        repeat (1000) @(negedge clk);
        wave_in = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkState("midReset", 0, 1, 0, 6);
        @(negedge clk);
        rst = 1'b0;
        repeat (898) @(negedge clk);
        applyStimulus(1000, 1000);
        checkState("fresh1", 0, 1, 0, 6);
        applyStimulus(1000, 1000);
        checkState("fresh2", 0, 1, 0, 6);
        applyStimulus(1000, 1000);
        checkState("fresh3", 1, 0, 1000, 7);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
